// File: rtl/ir_key_uart_tx_pkg.sv
// ir_key_uart_tx_pkg: UART line constants, byte-shifter states and ASCII hex framing helpers
package ir_key_uart_tx_pkg;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT = 1'b1;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} tx_state_t;
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction
    // Byte idx of a key frame: high nibble, low nibble, CR, LF
    function automatic logic [7:0] frame_byte(input logic [7:0] code, input logic [1:0] idx);
        return idx == 2'd0 ? hex_char(code[7:4]) : idx == 2'd1 ? hex_char(code[3:0]) : idx == 2'd2 ? ASCII_CR : ASCII_LF;
    endfunction
endpackage

// File: rtl/ir_key_uart_tx_if.sv
// ir_key_uart_tx_if: key code input and UART/status outputs of the IR key logger
interface ir_key_uart_tx_if;
    logic [7:0] key_code;
    logic tx;
    logic busy;
    logic key_strobe;
    modport master(output key_code, input tx, busy, key_strobe);
    modport slave(input key_code, output tx, busy, key_strobe);
endinterface

// File: rtl/ir_key_uart_tx_uart_tx_byte.sv
// uart_tx_byte: 8N1 byte shifter; a start asserted with done chains the next byte with no idle gap
module uart_tx_byte
    import ir_key_uart_tx_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       start,
    output logic       tx,
    output logic       done
);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    tx_state_t state, nxt;
    logic [CW-1:0] cnt;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic bit_end, load;
    assign bit_end = cnt == LAST;
    assign load = start && (state == ST_IDLE || done);
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= ST_IDLE;
        else state <= nxt;
    always_comb begin
        nxt = state == ST_IDLE ? (start ? ST_START : ST_IDLE) :
              !bit_end ? state :
              state == ST_START ? ST_DATA :
              state == ST_DATA ? (bit_idx == 3'd7 ? ST_STOP : ST_DATA) :
              (start ? ST_START : ST_IDLE);
    end
    always_comb begin
        tx = state == ST_START ? START_BIT : state == ST_DATA ? shreg[0] : STOP_BIT;
        done = state == ST_STOP && bit_end;
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            cnt <= '0;
            bit_idx <= 3'd0;
            shreg <= 8'hFF;
        end else begin
            cnt <= state == ST_IDLE || bit_end ? '0 : cnt + CW'(1);
            bit_idx <= state == ST_DATA ? bit_idx + 3'(bit_end) : 3'd0;
            shreg <= load ? data : state == ST_DATA && bit_end ? {1'b1, shreg[7:1]} : shreg;
        end
endmodule

// File: rtl/ir_key_uart_tx.sv
// ir_key_uart_tx: detects each newly decoded IR key and logs it over UART as two hex chars (+CR/LF)
module ir_key_uart_tx
    import ir_key_uart_tx_pkg::*;
#(
    parameter int         CLK_HZ    = 50_000_000,
    parameter int         BAUD      = 9600,
    parameter bit         SEND_CRLF = 1'b1,
    parameter logic [7:0] IDLE_CODE = 8'hC0
) (
    input logic clk,
    input logic rst,
    ir_key_uart_tx_if.slave bus
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam logic [1:0] LAST_BYTE = SEND_CRLF ? 2'd3 : 2'd1;
    logic [7:0] sync1, sync2, sync_prev, last_sent, pend_code, cur_code, tx_data;
    logic [1:0] byte_idx;
    logic pend_valid, busy, key_strobe, stable, new_key, load_seq, start, done, tx;
    // A value counts only once sync2 has held it for two clocks, which filters multi-bit skew
    assign stable = sync2 == sync_prev;
    assign new_key = stable && sync2 != last_sent && !(pend_valid && sync2 == pend_code);
    assign load_seq = !busy && pend_valid;
    assign start = load_seq || (done && byte_idx != LAST_BYTE);
    assign tx_data = load_seq ? frame_byte(pend_code, 2'd0) : frame_byte(cur_code, byte_idx + 2'd1);
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            sync1 <= IDLE_CODE;
            sync2 <= IDLE_CODE;
            sync_prev <= IDLE_CODE;
            last_sent <= IDLE_CODE;
            pend_code <= IDLE_CODE;
            cur_code <= IDLE_CODE;
            pend_valid <= 1'b0;
            key_strobe <= 1'b0;
            busy <= 1'b0;
            byte_idx <= 2'd0;
        end else begin
            sync1 <= bus.key_code;
            sync2 <= sync1;
            sync_prev <= sync2;
            key_strobe <= new_key;
            if (new_key) begin
                pend_code <= sync2;
                pend_valid <= 1'b1;
            end else if (load_seq) pend_valid <= 1'b0;
            if (load_seq) begin
                cur_code <= pend_code;
                last_sent <= pend_code;
                byte_idx <= 2'd0;
                busy <= 1'b1;
            end else if (done) begin
                busy <= byte_idx != LAST_BYTE;
                byte_idx <= byte_idx + 2'd1;
            end
        end
    uart_tx_byte #(.DIV(DIV)) u_tx (
        .clk(clk),
        .rst(rst),
        .data(tx_data),
        .start(start),
        .tx(tx),
        .done(done)
    );
    assign bus.tx = tx;
    assign bus.busy = busy;
    assign bus.key_strobe = key_strobe;
endmodule

// File: tb/tb_ir_key_uart_tx.sv
// tb_ir_key_uart_tx: UART-receiver based checks of the IR key logger, CRLF and hex-only variants
module tb_ir_key_uart_tx;
    localparam int DIV = 10;
    typedef struct {
        logic [7:0] code;
        logic [7:0] c_hi;
        logic [7:0] c_lo;
        bit         sent;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [1:0] txs;
    int total = 0, bad = 0, str0 = 0, str1 = 0, busy0 = 0, busy1 = 0, low0 = 0;
    logic [7:0] rx0[$], rx1[$], exp0[$], exp1[$];
    ir_key_uart_tx_if b0();
    ir_key_uart_tx_if b1();
    ir_key_uart_tx #(.CLK_HZ(1000), .BAUD(100), .SEND_CRLF(1'b1), .IDLE_CODE(8'hC0)) dut0 (
        .clk(clk), .rst(rst), .bus(b0));
    ir_key_uart_tx #(.CLK_HZ(1000), .BAUD(100), .SEND_CRLF(1'b0), .IDLE_CODE(8'hC0)) dut1 (
        .clk(clk), .rst(rst), .bus(b1));
    assign txs = {b1.tx, b0.tx};
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (b0.key_strobe) str0 <= str0 + 1;
        if (b1.key_strobe) str1 <= str1 + 1;
        if (b0.busy) busy0 <= busy0 + 1;
        if (b1.busy) busy1 <= busy1 + 1;
        if (rst && !b0.tx) low0 <= low0 + 1;
    end
    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask
    function automatic logic [7:0] hex_ref(input logic [3:0] n);
        return n > 4'd9 ? 8'("A" + n - 10) : 8'("0" + n);
    endfunction
    task automatic model_key(input int ch, input logic [7:0] code);
        if (ch == 0) begin
            exp0.push_back(hex_ref(code[7:4]));
            exp0.push_back(hex_ref(code[3:0]));
            exp0.push_back(8'h0D);
            exp0.push_back(8'h0A);
        end else begin
            exp1.push_back(hex_ref(code[7:4]));
            exp1.push_back(hex_ref(code[3:0]));
        end
    endtask
    task automatic chk_rx(input int ch, input string name);
        logic [7:0] g[$], e[$];
        if (ch == 0) begin
            g = rx0; e = exp0; rx0.delete(); exp0.delete();
        end else begin
            g = rx1; e = exp1; rx1.delete(); exp1.delete();
        end
        chk({name, ".len"}, g.size(), e.size());
        for (int i = 0; i < e.size() && i < g.size(); i++)
            chk($sformatf("%s.byte%0d", name, i), int'(g[i]), int'(e[i]));
    endtask
    task automatic wait_bits(input int n);
        for (int c = 0; c < n && rst; c++) @(negedge clk);
    endtask
    // Mid-bit sampling receiver; a frame touched by reset is discarded
    task automatic rx_loop(input int ch);
        logic [7:0] d;
        bit ok;
        forever begin
            @(negedge clk);
            if (rst && txs[ch] == 1'b0) begin
                wait_bits(DIV / 2 - 1);
                ok = rst && txs[ch] == 1'b0;
                for (int i = 0; i < 8; i++) begin
                    wait_bits(DIV);
                    d[i] = txs[ch];
                end
                wait_bits(DIV);
                ok = ok && rst && txs[ch] == 1'b1;
                if (ok && ch == 0) rx0.push_back(d);
                if (ok && ch == 1) rx1.push_back(d);
            end
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    initial rx_loop(0);
    initial rx_loop(1);
    initial begin
        vec_t tbl[7];
        int s, b, lat, r;
        bit exp_s;
        logic [7:0] code, last_model;
        tbl[0] = '{8'h1C, "1", "C", 1'b0};
        tbl[1] = '{8'hC0, "C", "0", 1'b1};
        tbl[2] = '{8'hC0, "C", "0", 1'b0};
        tbl[3] = '{8'hAF, "A", "F", 1'b1};
        tbl[4] = '{8'h09, "0", "9", 1'b1};
        tbl[5] = '{8'hFA, "F", "A", 1'b1};
        tbl[6] = '{8'h00, "0", "0", 1'b1};
        b0.key_code = 8'hC0;
        b1.key_code = 8'hC0;
        tick(3);
        chk("rst_tx", int'(b0.tx), 1);
        chk("rst_busy", int'(b0.busy), 0);
        chk("rst_strobe", int'(b0.key_strobe), 0);
        rst = 1'b1;
        tick(500);
        chk("idle_tx_low", low0, 0);
        chk("idle_busy", busy0, 0);
        chk("idle_strobe", str0, 0);
        chk_rx(0, "idle_rx");
        // single key: latency, busy width and byte content
        s = str0; b = busy0; lat = 0;
        b0.key_code = 8'h1C;
        while (b0.tx && lat < 20) begin
            tick(1);
            lat++;
        end
        chk("latency", lat, 5);
        tick(600 - lat);
        chk("k1C_strobe", str0 - s, 1);
        chk("k1C_busy", busy0 - b, 400);
        model_key(0, 8'h1C);
        chk_rx(0, "k1C");
        // latest pending key wins
        s = str0;
        b0.key_code = 8'h45;
        tick(50);
        b0.key_code = 8'h46;
        tick(100);
        b0.key_code = 8'h47;
        tick(800);
        chk("latest_strobe", str0 - s, 3);
        model_key(0, 8'h45);
        model_key(0, 8'h47);
        chk_rx(0, "latest");
        // one-clock glitch rejected
        s = str0;
        b0.key_code = 8'h44;
        tick(450);
        b0.key_code = 8'h00;
        tick(1);
        b0.key_code = 8'h40;
        tick(450);
        chk("glitch_strobe", str0 - s, 2);
        model_key(0, 8'h44);
        model_key(0, 8'h40);
        chk_rx(0, "glitch");
        // reset in the middle of byte 2
        b0.key_code = 8'h1C;
        tick(150);
        rst = 1'b0;
        #1;
        chk("midrst_tx", int'(b0.tx), 1);
        chk("midrst_busy", int'(b0.busy), 0);
        rx0.delete();
        tick(3);
        s = str0;
        rst = 1'b1;
        tick(500);
        chk("resend_strobe", str0 - s, 1);
        model_key(0, 8'h1C);
        chk_rx(0, "resend");
        for (int i = 0; i < 7; i++) begin
            s = str0; b = busy0;
            b0.key_code = tbl[i].code;
            tick(450);
            chk($sformatf("tbl%0d_strobe", i), str0 - s, int'(tbl[i].sent));
            chk($sformatf("tbl%0d_busy", i), busy0 - b, tbl[i].sent ? 400 : 0);
            if (tbl[i].sent) begin
                exp0.push_back(tbl[i].c_hi);
                exp0.push_back(tbl[i].c_lo);
                exp0.push_back(8'h0D);
                exp0.push_back(8'h0A);
            end
            chk_rx(0, $sformatf("tbl%0d", i));
        end
        last_model = 8'h00;
        for (int i = 0; i < 10; i++) begin
            r = $urandom_range(0, 3);
            code = r == 0 ? 8'hC0 : r == 1 ? last_model : 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                b0.key_code = 8'($urandom);
                tick(1);
            end
            s = str0;
            b0.key_code = code;
            tick(450);
            exp_s = code != last_model;
            if (exp_s) begin
                model_key(0, code);
                last_model = code;
            end
            chk($sformatf("rand%0d_strobe", i), str0 - s, int'(exp_s));
        end
        chk_rx(0, "rand");
        // hex-only variant
        s = str1; b = busy1;
        b1.key_code = 8'hAF;
        tick(300);
        chk("nocrlf_strobe", str1 - s, 1);
        chk("nocrlf_busy", busy1 - b, 200);
        model_key(1, 8'hAF);
        chk_rx(1, "nocrlf");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
